sio_uart_rx: RTL and testbench

- 8-bit asynchronous serial receiver (8N1, LSB first) for the serial link clocked by the SIO baud divider.
- Receive-side end of the serial line: samples `rxd` at 16x oversampling from the 50 MHz system clock.
- Delivers bytes through a valid/ready holding register to the Z80 bus interface.
- Reports framing and overrun errors as sticky flags.

---
 rtl/sio_uart_rx.sv | 161 ++++++++++++++++
 tb/tb_sio_uart_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sio_uart_rx.sv
// 8N1 UART receiver, 16x oversampled, with a valid/ready holding register and sticky error flags.
// Optional even-parity bit (8E1) when SIO_UART_RX_PARITY_EN is defined.
module sio_uart_rx #(
  parameter int SAMPLE_DIV = 326,
  parameter int OVS        = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr,
`ifdef SIO_UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int DW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PW = $clog2(OVS);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [PW-1:0] PH_MID   = PW'(OVS / 2 - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(OVS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            rxd_meta_q, rxs_q;
  logic [DW-1:0]   div_q, div_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            tick, at_mid, at_last, deliver, stop_bad;

  assign tick    = (div_q == DIV_LAST);
  assign at_mid  = tick && (phase_q == PH_MID);
  assign at_last = tick && (phase_q == PH_LAST);
  assign deliver  = (state_q == S_STOP) && at_last && rxs_q;
  assign stop_bad = (state_q == S_STOP) && at_last && !rxs_q;

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; every transition is qualified by a tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tick && !rxs_q) state_d = S_START;
      S_START:  if (at_mid) state_d = rxs_q ? S_IDLE : S_DATA;
`ifdef SIO_UART_RX_PARITY_EN
      S_DATA:   if (at_last && bit_q == 3'd7) state_d = S_PARITY;
      S_PARITY: if (at_last) state_d = S_STOP;
`else
      S_DATA:   if (at_last && bit_q == 3'd7) state_d = S_STOP;
`endif
      S_STOP:   if (at_last) state_d = rxs_q ? S_IDLE : S_BREAK;
      S_BREAK:  if (tick && rxs_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_comb begin
    div_d = tick ? '0 : div_q + DW'(1);

    phase_d = phase_q;
    if (tick) begin
      if (state_q == S_IDLE || state_q == S_BREAK || state_d != state_q || phase_q == PH_LAST)
        phase_d = '0;
      else
        phase_d = phase_q + PW'(1);
    end

    bit_d   = (state_q == S_START) ? 3'd0 : bit_q;
    shift_d = shift_q;
    if (state_q == S_DATA && at_last) begin
      bit_d   = bit_q + 3'd1;
      shift_d = {rxs_q, shift_q[7:1]};
    end

    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    overrun_d  = overrun_q && !err_clr;
    frame_err_d = frame_err_q && !err_clr;
    // A byte landing while the holder is full and not being read is dropped
    if (deliver) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (stop_bad) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rxd_meta_q  <= 1'b1;
      rxs_q       <= 1'b1;
      div_q       <= '0;
      phase_q     <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd;
      rxs_q       <= rxd_meta_q;
      div_q       <= div_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef SIO_UART_RX_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Even parity: data ones plus the parity bit must be even
  always_comb begin
    parity_err_d = parity_err_q && !err_clr;
    if (state_q == S_PARITY && at_last && ((^shift_q) ^ rxs_q)) parity_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`endif

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sio_uart_rx.sv
// Directed bench for sio_uart_rx: reset, handshake, overrun, false start, break, mid-frame reset.
// Parity cases are exercised when SIO_UART_RX_PARITY_EN is defined.
module tb_sio_uart_rx;

  localparam int SAMPLE_DIV = 4;
  localparam int OVS        = 16;
  localparam int BIT        = SAMPLE_DIV * OVS;

  logic       clk;
  logic       n_rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;
  logic       busy;
`ifdef SIO_UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip;
`endif

  int checks = 0;
  int errors = 0;

  sio_uart_rx #(.SAMPLE_DIV(SAMPLE_DIV), .OVS(OVS)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr),
`ifdef SIO_UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    rxd = 1'b0;
    clk_n(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      clk_n(BIT);
    end
`ifdef SIO_UART_RX_PARITY_EN
    rxd = (^d) ^ par_flip;
    clk_n(BIT);
`endif
    rxd = stop_v;
    clk_n(BIT);
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    clk_n(1);
    rx_ready = 1'b0;
  endtask

  logic [7:0] part;

  initial begin
    n_rst = 1'b0; rxd = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
`ifdef SIO_UART_RX_PARITY_EN
    par_flip = 1'b0;
`endif
    clk_n(4);
    check("rst_data",  rx_data,   8'h00);
    check("rst_valid", rx_valid,  1'b0);
    check("rst_ferr",  frame_err, 1'b0);
    check("rst_ovr",   overrun,   1'b0);
    check("rst_busy",  busy,      1'b0);
    n_rst = 1'b1;

    // Basic byte and handshake
    clk_n(2 * BIT);
    send_frame(8'h55, 1'b1);
    check("b55_valid", rx_valid, 1'b1);
    check("b55_data",  rx_data,  8'h55);
    accept();
    check("b55_taken", rx_valid,  1'b0);
    check("b55_ferr",  frame_err, 1'b0);
    check("b55_ovr",   overrun,   1'b0);

    // Overrun with consumer stalled
    send_frame(8'hA3, 1'b1);
    check("a3_data", rx_data, 8'hA3);
    send_frame(8'h3C, 1'b1);
    check("ovr_data",  rx_data,  8'hA3);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_flag",  overrun,  1'b1);
    err_clr = 1'b1;
    clk_n(1);
    err_clr = 1'b0;
    check("ovr_clr",      overrun, 1'b0);
    check("ovr_clr_data", rx_data, 8'hA3);
    accept();
    check("ovr_taken", rx_valid, 1'b0);

    // False start shorter than half a bit
    rxd = 1'b0;
    clk_n(4 * SAMPLE_DIV);
    check("fs_busy_hi", busy, 1'b1);
    rxd = 1'b1;
    clk_n(BIT);
    check("fs_busy_lo", busy,     1'b0);
    check("fs_valid",   rx_valid, 1'b0);

    // Framing error followed by a held-low line
    send_frame(8'hF0, 1'b0);
    clk_n(3 * BIT);
    check("fe_flag",  frame_err, 1'b1);
    check("fe_valid", rx_valid,  1'b0);
    check("brk_busy", busy,      1'b1);
    rxd = 1'b1;
    clk_n(2 * SAMPLE_DIV + 4);
    check("brk_exit", busy, 1'b0);
    clk_n(BIT);
    send_frame(8'h81, 1'b1);
    check("b81_data",   rx_data,   8'h81);
    check("b81_valid",  rx_valid,  1'b1);
    check("b81_sticky", frame_err, 1'b1);
    accept();

    // Reset during bit 4 of 0xC7
    part = 8'hC7;
    rxd = 1'b0;
    clk_n(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = part[i];
      clk_n(BIT);
    end
    rxd = part[4];
    clk_n(BIT / 2);
    check("mid_busy", busy, 1'b1);
    n_rst = 1'b0;
    rxd = 1'b1;
    clk_n(3);
    n_rst = 1'b1;
    check("mr_busy",  busy,      1'b0);
    check("mr_valid", rx_valid,  1'b0);
    check("mr_ferr",  frame_err, 1'b0);
    clk_n(2 * BIT);
    send_frame(8'h12, 1'b1);
    check("b12_data",  rx_data,   8'h12);
    check("b12_valid", rx_valid,  1'b1);
    check("b12_ferr",  frame_err, 1'b0);
    check("b12_ovr",   overrun,   1'b0);
    accept();

`ifdef SIO_UART_RX_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    par_flip = 1'b0;
    check("par_bad_data", rx_data,    8'h07);
    check("par_bad_flag", parity_err, 1'b1);
    accept();
    send_frame(8'h07, 1'b1);
    check("par_ok_data",   rx_data,    8'h07);
    check("par_ok_sticky", parity_err, 1'b1);
    err_clr = 1'b1;
    clk_n(1);
    err_clr = 1'b0;
    check("par_clr", parity_err, 1'b0);
    accept();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
